// File: rtl/anabellek_yanitlayici_pkg.sv
// Shared iomem definitions: bus widths and responder/controller FSM state encodings.
package anabellek_yanitlayici_pkg;
   localparam int unsigned IOMEM_DW = 32;
   localparam int unsigned IOMEM_SW = 4;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      BEKLE = 2'd1,
      ERIS  = 2'd2,
      YANIT = 2'd3
   } durum_t;
endpackage

// File: rtl/anabellek_yanitlayici.sv
// iomem responder: serves one request at a time from a 1-cycle-latency word SRAM
// macro, with programmable wait states and a sticky out-of-window flag.
module anabellek_yanitlayici
   import anabellek_yanitlayici_pkg::*;
#(
   parameter int unsigned ADR_BIT = 17,
   parameter logic [31:0] TABAN   = 32'h4000_0000,
   parameter int unsigned BEKLEME = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                iomem_valid,
   output logic                iomem_ready,
   input  logic [IOMEM_SW-1:0] iomem_wstrb,
   input  logic [31:0]         iomem_addr,
   input  logic [IOMEM_DW-1:0] iomem_wdata,
   output logic [IOMEM_DW-1:0] iomem_rdata,
   output logic                mem_en_o,
   output logic [IOMEM_SW-1:0] mem_we_o,
   output logic [ADR_BIT-1:0]  mem_adr_o,
   output logic [IOMEM_DW-1:0] mem_wdata_o,
   input  logic [IOMEM_DW-1:0] mem_rdata_i,
   output logic                hata_o
);
   localparam logic [3:0] SAYAC_BAS = (BEKLEME == 0) ? 4'd0 : 4'(BEKLEME - 1);

   durum_t              durum;
   logic [3:0]          sayac;
   logic [ADR_BIT-1:0]  adr_q;
   logic [IOMEM_SW-1:0] wstrb_q;
   logic [IOMEM_DW-1:0] wdata_q;
   logic                isabet_q;
   logic                okuma_isabet;

   logic                s_isabet;
   logic [ADR_BIT-1:0]  s_adr;
   logic [IOMEM_SW-1:0] s_wstrb;
   logic [IOMEM_DW-1:0] s_wdata;
   logic                eris_gir;
   logic                unused_adr_lsb;

   assign unused_adr_lsb = ^iomem_addr[1:0];

   // ERIS is entered either straight from BOSTA (no wait states, live inputs)
   // or from BEKLE (latched copies); both paths share one set of operands.
   always_comb begin
      s_isabet = isabet_q;
      s_adr    = adr_q;
      s_wstrb  = wstrb_q;
      s_wdata  = wdata_q;
      if (durum == BOSTA) begin
         s_isabet = (iomem_addr[31:ADR_BIT+2] == TABAN[31:ADR_BIT+2]);
         s_adr    = iomem_addr[ADR_BIT+1:2];
         s_wstrb  = iomem_wstrb;
         s_wdata  = iomem_wdata;
      end
      eris_gir = ((durum == BOSTA) && iomem_valid && (BEKLEME == 0)) ||
                 ((durum == BEKLE) && (sayac == 4'd0));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum        <= BOSTA;
         sayac        <= '0;
         adr_q        <= '0;
         wstrb_q      <= '0;
         wdata_q      <= '0;
         isabet_q     <= 1'b0;
         okuma_isabet <= 1'b0;
         iomem_ready  <= 1'b0;
         mem_en_o     <= 1'b0;
         mem_we_o     <= '0;
         mem_adr_o    <= '0;
         mem_wdata_o  <= '0;
         hata_o       <= 1'b0;
      end else begin
         iomem_ready  <= 1'b0;
         okuma_isabet <= 1'b0;
         mem_en_o     <= 1'b0;
         mem_we_o     <= '0;
         mem_adr_o    <= '0;
         mem_wdata_o  <= '0;

         if (eris_gir) begin
            mem_en_o    <= s_isabet;
            mem_we_o    <= s_isabet ? s_wstrb : '0;
            mem_adr_o   <= s_isabet ? s_adr : '0;
            mem_wdata_o <= s_isabet ? s_wdata : '0;
         end

         case (durum)
            BOSTA: begin
               if (iomem_valid) begin
                  adr_q    <= s_adr;
                  wstrb_q  <= s_wstrb;
                  wdata_q  <= s_wdata;
                  isabet_q <= s_isabet;
                  sayac    <= SAYAC_BAS;
                  durum    <= (BEKLEME == 0) ? ERIS : BEKLE;
               end
            end
            BEKLE: begin
               if (sayac == 4'd0) durum <= ERIS;
               else               sayac <= sayac - 4'd1;
            end
            ERIS: begin
               iomem_ready  <= 1'b1;
               okuma_isabet <= isabet_q && (wstrb_q == '0);
               if (!isabet_q) hata_o <= 1'b1;
               durum <= YANIT;
            end
            default: durum <= BOSTA;
         endcase
      end
   end

   // Macro data arrives in the YANIT cycle itself, so rdata is gated, not registered.
   assign iomem_rdata = okuma_isabet ? mem_rdata_i : '0;
endmodule

// File: tb/tb_anabellek_yanitlayici.sv
// Bench for anabellek_yanitlayici: three instances (2, 0 and 15 wait states),
// each backed by a small SRAM macro model.
module tb_anabellek_yanitlayici;
   localparam int unsigned WS [3] = '{2, 0, 15};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]        valid = '0;
   logic [2:0]        ready;
   logic [2:0][3:0]   wstrb = '0;
   logic [2:0][31:0]  addr  = '0;
   logic [2:0][31:0]  wdata = '0;
   logic [2:0][31:0]  rdata;
   logic [2:0]        mem_en;
   logic [2:0][3:0]   mem_we;
   logic [2:0][16:0]  mem_adr;
   logic [2:0][31:0]  mem_wd;
   logic [2:0]        hata;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [31:0] sram [1024];
      logic [31:0] rd;
      anabellek_yanitlayici #(
         .ADR_BIT(17),
         .TABAN  (32'h4000_0000),
         .BEKLEME(WS[g])
      ) u_dut (
         .clk_i      (clk),
         .rst_i      (rst),
         .iomem_valid(valid[g]),
         .iomem_ready(ready[g]),
         .iomem_wstrb(wstrb[g]),
         .iomem_addr (addr[g]),
         .iomem_wdata(wdata[g]),
         .iomem_rdata(rdata[g]),
         .mem_en_o   (mem_en[g]),
         .mem_we_o   (mem_we[g]),
         .mem_adr_o  (mem_adr[g]),
         .mem_wdata_o(mem_wd[g]),
         .mem_rdata_i(rd),
         .hata_o     (hata[g])
      );
      always @(posedge clk) begin
         if (mem_en[g]) begin
            for (int b = 0; b < 4; b++)
               if (mem_we[g][b]) sram[mem_adr[g][9:0]][8*b +: 8] <= mem_wd[g][8*b +: 8];
            rd <= sram[mem_adr[g][9:0]];
         end
      end
   end

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   logic [2:0]  hata_exp = '0;
   logic [31:0] ref_mem [int unsigned];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return (a >= 32'h4000_0000) && (a < 32'h4008_0000);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   task automatic xact(input int k, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp_rd, input string nm);
      int unsigned b = WS[k];
      bit hit = in_window(a);
      int rdy_n = 0, rdy_c = -1, en_n = 0, en_c = -1, we_stray = 0;
      logic [3:0]  we_seen = '0;
      logic [16:0] adr_seen = '0;
      logic [31:0] wd_seen = '0, rd = '0;
      @(negedge clk);
      valid[k] = 1'b1; addr[k] = a; wstrb[k] = s; wdata[k] = d;
      for (int c = 1; c <= int'(b) + 6; c++) begin
         @(negedge clk);
         if (mem_en[k]) begin
            en_n++; en_c = c; we_seen = mem_we[k]; adr_seen = mem_adr[k]; wd_seen = mem_wd[k];
         end else if (mem_we[k] != '0) we_stray++;
         if (ready[k]) begin
            rdy_n++; rdy_c = c; rd = rdata[k]; valid[k] = 1'b0;
         end
      end
      valid[k] = 1'b0;
      if (!hit) hata_exp[k] = 1'b1;
      if (k == 0 && hit && s != '0) ref_mem[a[18:2]] = merge(ref_mem[a[18:2]], d, s);
      chk({nm, " ready_cycle"}, rdy_c, b + 2);
      chk({nm, " ready_count"}, rdy_n, 1);
      chk({nm, " rdata"}, rd, exp_rd);
      chk({nm, " en_count"}, en_n, hit ? 1 : 0);
      chk({nm, " we_stray"}, we_stray, 0);
      chk({nm, " hata"}, {31'b0, hata[k]}, {31'b0, hata_exp[k]});
      if (hit) begin
         chk({nm, " en_cycle"}, en_c, b + 1);
         chk({nm, " we"}, {28'b0, we_seen}, {28'b0, s});
         chk({nm, " adr"}, {15'b0, adr_seen}, {15'b0, a[18:2]});
         chk({nm, " mem_wdata"}, wd_seen, d);
      end
   endtask

   typedef struct packed {
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [31:0] bb [3];
      int          nrdy, j;

      tbl[0]  = '{32'h4000_0040, 4'hF, 32'hCAFE_F00D, 32'h0};
      tbl[1]  = '{32'h4000_0040, 4'h0, 32'h0,         32'hCAFE_F00D};
      tbl[2]  = '{32'h4000_0040, 4'hF, 32'h1122_3344, 32'h0};
      tbl[3]  = '{32'h4000_0040, 4'h4, 32'h00AB_0000, 32'h0};
      tbl[4]  = '{32'h4000_0040, 4'h0, 32'h0,         32'h11AB_3344};
      tbl[5]  = '{32'h2000_0000, 4'hF, 32'h1234_5678, 32'h0};
      tbl[6]  = '{32'h2000_0000, 4'h0, 32'h0,         32'h0};
      tbl[7]  = '{32'h4000_0040, 4'h0, 32'h0,         32'h11AB_3344};
      tbl[8]  = '{32'h4007_FFFC, 4'hF, 32'hDEAD_BEEF, 32'h0};
      tbl[9]  = '{32'h4007_FFFC, 4'h0, 32'h0,         32'hDEAD_BEEF};
      tbl[10] = '{32'h4008_0000, 4'h0, 32'h0,         32'h0};
      tbl[11] = '{32'h3FFF_FFFC, 4'h0, 32'h0,         32'h0};
      tbl[12] = '{32'h4000_0043, 4'h1, 32'h0000_00EE, 32'h0};
      tbl[13] = '{32'h4000_0041, 4'h0, 32'h0,         32'h11AB_33EE};

      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst%0d ready", k), {31'b0, ready[k]}, 32'h0);
         chk($sformatf("rst%0d rdata", k), rdata[k], 32'h0);
         chk($sformatf("rst%0d en_we", k), {27'b0, mem_en[k], mem_we[k]}, 32'h0);
         chk($sformatf("rst%0d hata", k), {31'b0, hata[k]}, 32'h0);
      end

      for (int i = 0; i < 14; i++)
         xact(0, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].exp, $sformatf("tbl%0d", i));

      // reset during BEKLE of a write
      @(negedge clk);
      valid[0] = 1'b1; addr[0] = 32'h4000_0040; wstrb[0] = 4'hF; wdata[0] = 32'h5555_5555;
      @(negedge clk);
      rst = 1'b1; valid[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0; hata_exp = '0;
      nrdy = 0;
      for (int c = 0; c < 6; c++) begin
         if (ready[0] || mem_en[0] || mem_we[0] != '0) nrdy++;
         @(negedge clk);
      end
      chk("midrst activity", nrdy, 0);
      chk("midrst hata", {31'b0, hata[0]}, 32'h0);
      xact(0, 32'h4000_0040, 4'h0, 32'h0, 32'h11AB_33EE, "midrst readback");

      // back-to-back reads, no wait states
      bb = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
      for (int i = 0; i < 3; i++)
         xact(1, 32'h4000_0000 + 32'(4 * i), 4'hF, bb[i], 32'h0, $sformatf("b2b_wr%0d", i));
      @(negedge clk);
      valid[1] = 1'b1; addr[1] = 32'h4000_0000; wstrb[1] = 4'h0; wdata[1] = '0;
      j = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (ready[1]) begin
            if (j < 3) begin
               chk($sformatf("b2b%0d cycle", j), c, 2 + 3 * j);
               chk($sformatf("b2b%0d rdata", j), rdata[1], bb[j]);
            end
            j++;
            if (j >= 3) valid[1] = 1'b0;
            else addr[1] = 32'h4000_0000 + 32'(4 * j);
         end
      end
      valid[1] = 1'b0;
      chk("b2b ready_count", j, 3);

      // maximum wait states
      xact(2, 32'h4000_0014, 4'hF, 32'h0F0F_1234, 32'h0, "max_wr");
      xact(2, 32'h4000_0014, 4'h0, 32'h0, 32'h0F0F_1234, "max_rd");

      // randomized traffic against the reference memory
      for (int w = 0; w < 16; w++)
         xact(0, 32'h4000_0000 + 32'(4 * w), 4'hF, $urandom, 32'h0, $sformatf("init%0d", w));
      for (int i = 0; i < 40; i++) begin
         int unsigned w = $urandom_range(0, 15);
         bit          miss = ($urandom_range(0, 7) == 0);
         logic [3:0]  s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         logic [31:0] a = miss ? (32'h8000_0000 | ($urandom & 32'h0FFF_FFFF))
                               : 32'h4000_0000 + 32'(4 * w) + 32'($urandom_range(0, 3));
         logic [31:0] e = (!miss && s == 4'h0) ? ref_mem[w] : 32'h0;
         xact(0, a, s, $urandom, e, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
